// File: rtl/noc_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_sched_pkg
//  Description : Shared sizes, types and helpers for the oldest-first
//                NoC output-link scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_sched_pkg;

   localparam int NUM_PORTS = 4;
   localparam int DATA_W    = 8;
   localparam int AGE_W     = 8;

   typedef logic [1:0]       port_idx_t;
   typedef logic [AGE_W-1:0] age_t;

   localparam age_t AGE_MAX = '1;

   // Saturating increment: a waiting flit never appears younger than it is
   function automatic age_t age_sat_inc(input age_t a);
      return (a == AGE_MAX) ? a : a + age_t'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/oldest_select.sv
`default_nettype none
// ============================================================================
//  Module      : oldest_select
//  Description : Combinational winner search. Picks the valid slot with the
//                largest age; ties go to the first such slot found scanning
//                upward (mod 4) from the round-robin pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module oldest_select
   import noc_sched_pkg::*;
(
   input  logic [NUM_PORTS-1:0]       slot_valid_i,
   input  age_t [NUM_PORTS-1:0]       slot_age_i,
   input  port_idx_t                  rr_i,
   output port_idx_t                  winner_o,
   output logic                       any_valid_o
);

   age_t      w_max_age;
   port_idx_t w_idx;
   logic      w_found;

   // Two passes: find the oldest age present, then the first holder of it from rr
   always_comb begin
      w_max_age = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (slot_valid_i[i] && (slot_age_i[i] > w_max_age)) begin
            w_max_age = slot_age_i[i];
         end
      end

      winner_o = rr_i;
      w_found  = 1'b0;
      w_idx    = rr_i;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_idx = rr_i + port_idx_t'(k);
         if (!w_found && slot_valid_i[w_idx] && (slot_age_i[w_idx] == w_max_age)) begin
            winner_o = w_idx;
            w_found  = 1'b1;
         end
      end

      any_valid_o = |slot_valid_i;
   end

endmodule
`default_nettype wire

// File: rtl/noc_age_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : noc_age_scheduler
//  Description : Oldest-first scheduler sharing one output link between four
//                input ports. Each port owns a single-entry holding slot that
//                ages while waiting; the output register is refilled with the
//                oldest flit whenever it is empty or being drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_age_scheduler
   import noc_sched_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        in_valid_i,
   input  logic [NUM_PORTS*DATA_W-1:0] in_data_i,
   output logic [NUM_PORTS-1:0]        in_ready_o,
   output logic                        out_valid_o,
   output logic [DATA_W-1:0]           out_data_o,
   output port_idx_t                   out_port_o,
   output age_t                        out_age_o,
   input  logic                        out_ready_i
);

   logic [NUM_PORTS-1:0]             slot_valid_q, slot_valid_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0] slot_data_q,  slot_data_d;
   age_t [NUM_PORTS-1:0]             slot_age_q,   slot_age_d;
   port_idx_t                        rr_q,         rr_d;
   logic                             out_valid_q,  out_valid_d;
   logic [DATA_W-1:0]                out_data_q,   out_data_d;
   port_idx_t                        out_port_q,   out_port_d;
   age_t                             out_age_q,    out_age_d;

   port_idx_t w_winner;
   logic      w_any_valid;
   logic      w_load;

   oldest_select u_oldest_select (
      .slot_valid_i (slot_valid_q),
      .slot_age_i   (slot_age_q),
      .rr_i         (rr_q),
      .winner_o     (w_winner),
      .any_valid_o  (w_any_valid)
   );

   // Slot-free flags come straight from state; held low while in reset
   assign in_ready_o  = ~slot_valid_q & {NUM_PORTS{reset}};

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_port_o  = out_port_q;
   assign out_age_o   = out_age_q;

   // Output register refills when empty or being accepted this cycle
   assign w_load = (!out_valid_q || out_ready_i) && w_any_valid;

   // Next-state: aging, grant, output update, then capture into free slots
   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_data_d  = slot_data_q;
      slot_age_d   = slot_age_q;
      rr_d         = rr_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_port_d   = out_port_q;
      out_age_d    = out_age_q;

      for (int i = 0; i < NUM_PORTS; i++) begin
         if (slot_valid_q[i] && !(w_load && (w_winner == port_idx_t'(i)))) begin
            slot_age_d[i] = age_sat_inc(slot_age_q[i]);
         end
      end

      if (w_load) begin
         out_valid_d            = 1'b1;
         out_data_d             = slot_data_q[w_winner];
         out_port_d             = w_winner;
         out_age_d              = slot_age_q[w_winner];
         slot_valid_d[w_winner] = 1'b0;
         rr_d                   = w_winner + port_idx_t'(1);
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end

      // A slot granted this edge was occupied, so it cannot also capture here
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (in_valid_i[i] && !slot_valid_q[i]) begin
            slot_valid_d[i] = 1'b1;
            slot_data_d[i]  = in_data_i[i*DATA_W +: DATA_W];
            slot_age_d[i]   = '0;
         end
      end
   end

   // State registers; reset discards every slot and the output flit at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_valid_q <= '0;
         slot_data_q  <= '0;
         slot_age_q   <= '0;
         rr_q         <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_port_q   <= '0;
         out_age_q    <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_data_q  <= slot_data_d;
         slot_age_q   <= slot_age_d;
         rr_q         <= rr_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_port_q   <= out_port_d;
         out_age_q    <= out_age_d;
      end
   end

endmodule
`default_nettype wire
